// File: rtl/pi1q_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pi1q_pkg
// Description : Shared definitions for the pi1q perint bridge: perint op
//               encodings, bridge FSM states and width helper functions.
// Revision    : 1.0  initial release
// ============================================================================
package pi1q_pkg;

  // Perint operation encodings.
  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  // Bridge control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // accepting master ops, writes are posted
    ST_DRAIN = 2'd1,  // read held, waiting for earlier writes to reach the slave
    ST_ISSUE = 2'd2,  // read presented to the slave
    ST_RESP  = 2'd3   // read accepted, waiting for its data
  } pi1q_state_e;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Word address width for a given data width: byte offset bits are dropped.
  function automatic int addrbitsz(input int archbitsz);
    return archbitsz - clog2(archbitsz / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pi1q_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pi1q_fifo
// Description : Synchronous FIFO holding posted writes for the pi1q bridge.
//               Head entry is visible combinationally on data_o.
// Ports       : clk_i, rst_i   clock, asynchronous active-high reset
//               push_i, data_i enqueue request and entry
//               pop_i          dequeue request (ignored when empty)
//               data_o         current head entry
//               full_o/empty_o occupancy flags
//               cnt_o          occupancy, 0..DEPTH
// Revision    : 1.0  initial release
// ============================================================================
module pi1q_fifo
  import pi1q_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTRW = clog2(DEPTH),
  localparam int CNTW = PTRW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNTW-1:0]  cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pointers wrap naturally: DEPTH is a power of two.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTRW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTRW'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CNTW'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CNTW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/pi1q.sv
`default_nettype none
// ============================================================================
// Module      : pi1q
// Description : Perint master-to-slave bridge with a DEPTH-entry posted-write
//               queue. Writes complete to the master when queued and drain to
//               the slave in order; reads and read-writes wait until every
//               earlier write has been accepted by the slave.
// Ports       : clk_i, rst_i         clock, asynchronous active-high reset
//               m_op_i/m_addr_i/m_data_i/m_sel_i  master request
//               m_data_o, m_rdy_o    master read data and ready (registered)
//               s_op_o/s_addr_o/s_data_o/s_sel_o  slave request (registered)
//               s_data_i, s_rdy_i    slave read data and ready
//               wq_cnt_o             write-queue occupancy (registered)
// Revision    : 1.0  initial release
// ============================================================================
module pi1q
  import pi1q_pkg::*;
#(
  parameter int ARCHBITSZ = 16,
  parameter int DEPTH     = 4,
  localparam int ADDRBITSZ = addrbitsz(ARCHBITSZ),
  localparam int SELW      = ARCHBITSZ / 8,
  localparam int CNTW      = clog2(DEPTH) + 1,
  localparam int FIFOW     = ADDRBITSZ + ARCHBITSZ + SELW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           m_op_i,
  input  logic [ADDRBITSZ-1:0] m_addr_i,
  input  logic [ARCHBITSZ-1:0] m_data_i,
  input  logic [SELW-1:0]      m_sel_i,
  output logic [ARCHBITSZ-1:0] m_data_o,
  output logic                 m_rdy_o,
  output logic [1:0]           s_op_o,
  output logic [ADDRBITSZ-1:0] s_addr_o,
  output logic [ARCHBITSZ-1:0] s_data_o,
  output logic [SELW-1:0]      s_sel_o,
  input  logic [ARCHBITSZ-1:0] s_data_i,
  input  logic                 s_rdy_i,
  output logic [CNTW-1:0]      wq_cnt_o
);

  pi1q_state_e          state_q, state_d;
  logic                 m_rdy_q, m_rdy_d;
  logic [ARCHBITSZ-1:0] m_data_q, m_data_d;
  logic [1:0]           s_op_q, s_op_d;
  logic [ADDRBITSZ-1:0] s_addr_q, s_addr_d;
  logic [ARCHBITSZ-1:0] s_data_q, s_data_d;
  logic [SELW-1:0]      s_sel_q, s_sel_d;
  logic [1:0]           hold_op_q, hold_op_d;
  logic [ADDRBITSZ-1:0] hold_addr_q, hold_addr_d;
  logic [ARCHBITSZ-1:0] hold_data_q, hold_data_d;
  logic [SELW-1:0]      hold_sel_q, hold_sel_d;

  logic                 m_acc, m_wr_acc, m_rd_acc;
  logic                 s_load;
  logic                 wq_push, wq_pop, wq_full, wq_empty;
  logic [FIFOW-1:0]     wq_head;
  logic [ADDRBITSZ-1:0] head_addr;
  logic [ARCHBITSZ-1:0] head_data;
  logic [SELW-1:0]      head_sel;
  logic [CNTW-1:0]      wq_cnt, cnt_nxt;

  // Only IDLE ever drives m_rdy_o high, so the state qualifier is defensive.
  assign m_acc    = m_rdy_q && (m_op_i != PINOOP) && (state_q == ST_IDLE);
  assign m_wr_acc = m_acc && (m_op_i == PIWROP);
  assign m_rd_acc = m_acc && m_op_i[1];

  // The output stage is free when empty or when its current op is being taken.
  assign s_load  = (s_op_q == PINOOP) || s_rdy_i;
  assign wq_pop  = s_load && !wq_empty;
  assign wq_push = m_wr_acc && (!wq_full || wq_pop);

  assign {head_addr, head_data, head_sel} = wq_head;

  pi1q_fifo #(
    .WIDTH (FIFOW),
    .DEPTH (DEPTH)
  ) u_wq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wq_push),
    .pop_i   (wq_pop),
    .data_i  ({m_addr_i, m_data_i, m_sel_i}),
    .data_o  (wq_head),
    .full_o  (wq_full),
    .empty_o (wq_empty),
    .cnt_o   (wq_cnt)
  );

  // Occupancy after this edge; m_rdy_o is registered alongside it.
  always_comb begin
    cnt_nxt = wq_cnt;
    if (wq_push && !wq_pop)      cnt_nxt = wq_cnt + CNTW'(1);
    else if (!wq_push && wq_pop) cnt_nxt = wq_cnt - CNTW'(1);
  end

  always_comb begin
    state_d     = state_q;
    m_rdy_d     = m_rdy_q;
    m_data_d    = m_data_q;
    s_op_d      = s_op_q;
    s_addr_d    = s_addr_q;
    s_data_d    = s_data_q;
    s_sel_d     = s_sel_q;
    hold_op_d   = hold_op_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_sel_d  = hold_sel_q;

    // Output stage: queued writes always go first, which keeps reads ordered
    // behind them. The held op is issued only once, while the stage is idle.
    if (s_load) begin
      if (!wq_empty) begin
        s_op_d   = PIWROP;
        s_addr_d = head_addr;
        s_data_d = head_data;
        s_sel_d  = head_sel;
      end else if ((state_q == ST_ISSUE) && (s_op_q == PINOOP)) begin
        s_op_d   = hold_op_q;
        s_addr_d = hold_addr_q;
        s_data_d = hold_data_q;
        s_sel_d  = hold_sel_q;
      end else begin
        s_op_d   = PINOOP;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (m_rd_acc) begin
          hold_op_d   = m_op_i;
          hold_addr_d = m_addr_i;
          hold_data_d = m_data_i;
          hold_sel_d  = m_sel_i;
          m_rdy_d     = 1'b0;
          state_d     = ST_DRAIN;
        end else begin
          m_rdy_d = (cnt_nxt != CNTW'(DEPTH));
        end
      end
      ST_DRAIN: begin
        // The last write must have left the output stage, not just the queue.
        if (wq_empty && ((s_op_q == PINOOP) || s_rdy_i)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if ((s_op_q != PINOOP) && s_rdy_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (s_rdy_i) begin
          m_data_d = s_data_i;
          m_rdy_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      m_rdy_q     <= 1'b1;
      m_data_q    <= '0;
      s_op_q      <= PINOOP;
      s_addr_q    <= '0;
      s_data_q    <= '0;
      s_sel_q     <= '0;
      hold_op_q   <= PINOOP;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      hold_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      m_rdy_q     <= m_rdy_d;
      m_data_q    <= m_data_d;
      s_op_q      <= s_op_d;
      s_addr_q    <= s_addr_d;
      s_data_q    <= s_data_d;
      s_sel_q     <= s_sel_d;
      hold_op_q   <= hold_op_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
    end
  end

  assign m_rdy_o  = m_rdy_q;
  assign m_data_o = m_data_q;
  assign s_op_o   = s_op_q;
  assign s_addr_o = s_addr_q;
  assign s_data_o = s_data_q;
  assign s_sel_o  = s_sel_q;
  assign wq_cnt_o = wq_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pi1q.sv
`default_nettype none
// ============================================================================
// Module      : tb_pi1q
// Description : Self-checking bench for pi1q (ARCHBITSZ=16, DEPTH=4).
//               A transaction-level model tracks master ops in order, the
//               write backlog and the outstanding read; a negedge process
//               compares the DUT against it every cycle. Directed sequences
//               add hand-computed literal checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pi1q;

  localparam int DEPTH = 4;
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] RW  = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [14:0] addr;
    logic [15:0] data;
    logic [1:0]  sel;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  m_op_i;
  logic [14:0] m_addr_i;
  logic [15:0] m_data_i;
  logic [1:0]  m_sel_i;
  logic [15:0] m_data_o;
  logic        m_rdy_o;
  logic [1:0]  s_op_o;
  logic [14:0] s_addr_o;
  logic [15:0] s_data_o;
  logic [1:0]  s_sel_o;
  logic [15:0] s_data_i;
  logic        s_rdy_i;
  logic [2:0]  wq_cnt_o;

  pi1q #(.ARCHBITSZ(16), .DEPTH(DEPTH)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .m_op_i   (m_op_i),
    .m_addr_i (m_addr_i),
    .m_data_i (m_data_i),
    .m_sel_i  (m_sel_i),
    .m_data_o (m_data_o),
    .m_rdy_o  (m_rdy_o),
    .s_op_o   (s_op_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_sel_o  (s_sel_o),
    .s_data_i (s_data_i),
    .s_rdy_i  (s_rdy_i),
    .wq_cnt_o (wq_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  txn_t        exp_q[$];      // master ops not yet taken by the slave, in order
  int          acc_wr;        // writes accepted from the master
  int          pres_wr;       // writes that have reached the slave interface
  bit          rd_busy;       // a read/read-write is outstanding toward the master
  bit          rd_wait_data;  // slave has taken the read, data still to come
  logic [15:0] exp_mdata;
  logic [1:0]  prev_sop;
  bit          prev_acc;
  int          n_sacc = 0;    // slave accepts seen (never reset)
  txn_t        last_sacc;

  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      acc_wr = 0; pres_wr = 0; rd_busy = 0; rd_wait_data = 0;
      exp_mdata = '0; prev_sop = NOP; prev_acc = 0;
    end else begin
      // A write leaves the backlog when it newly appears on the slave side.
      if (s_op_o === WR && (prev_sop === NOP || prev_acc)) pres_wr++;
      chk("wq_cnt", 32'(wq_cnt_o), 32'(acc_wr - pres_wr));
      chk("m_rdy", 32'(m_rdy_o), 32'(!rd_busy && ((acc_wr - pres_wr) != DEPTH)));
      chk("m_data", 32'(m_data_o), 32'(exp_mdata));
      // Read data arrives at the first ready cycle after the slave took the read.
      if (rd_wait_data && s_rdy_i) begin
        exp_mdata = s_data_i;
        rd_busy = 0;
        rd_wait_data = 0;
      end
      if (s_op_o !== NOP && s_rdy_i) begin
        n_sacc++;
        last_sacc = '{op: s_op_o, addr: s_addr_o, data: s_data_o, sel: s_sel_o};
        if (exp_q.size() == 0) begin
          chk("unexpected_s_op", 32'(s_op_o), 32'(NOP));
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          chk("s_op", 32'(s_op_o), 32'(t.op));
          chk("s_addr", 32'(s_addr_o), 32'(t.addr));
          chk("s_data", 32'(s_data_o), 32'(t.data));
          chk("s_sel", 32'(s_sel_o), 32'(t.sel));
          if (t.op[1]) rd_wait_data = 1;
        end
      end
      prev_sop = s_op_o;
      prev_acc = (s_op_o !== NOP) && s_rdy_i;
      if (m_rdy_o && m_op_i !== NOP) begin
        exp_q.push_back('{op: m_op_i, addr: m_addr_i, data: m_data_i, sel: m_sel_i});
        if (m_op_i == WR) acc_wr++;
        else rd_busy = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present an op until the bridge takes it; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [14:0] a,
                      input logic [15:0] d, input logic [1:0] s);
    int n;
    n = 0;
    m_op_i = op; m_addr_i = a; m_data_i = d; m_sel_i = s;
    @(negedge clk);
    while (!m_rdy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(m_rdy_o), 32'd1);
    cyc();
    m_op_i = NOP;
  endtask

  // Wait until the bridge is ready with nothing queued or in flight.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(m_rdy_o && wq_cnt_o == 0 && s_op_o == NOP) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'(m_rdy_o), 32'd1);
    cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    logic [2:0] exp_cnt [5];
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

    rst_i = 1'b1; m_op_i = NOP; m_addr_i = '0; m_data_i = '0; m_sel_i = '0;
    s_data_i = '0; s_rdy_i = 1'b0;
    repeat (3) cyc();
    chk("rst_m_rdy", 32'(m_rdy_o), 32'd1);
    chk("rst_m_data", 32'(m_data_o), 32'd0);
    chk("rst_s_op", 32'(s_op_o), 32'(NOP));
    chk("rst_s_addr", 32'(s_addr_o), 32'd0);
    chk("rst_wq_cnt", 32'(wq_cnt_o), 32'd0);
    rst_i = 1'b0;
    cyc();

    // Posted writes with a stalled slave: first write moves to the output
    // stage, the next four fill the queue.
    for (int i = 0; i < 5; i++) begin
      send(WR, 15'(16'h10 + i), 16'(16'hA0 + i), 2'b11);
      chk("post_wq_cnt", 32'(wq_cnt_o), 32'(exp_cnt[i]));
      chk("post_m_rdy", 32'(m_rdy_o), (i < 4) ? 32'd1 : 32'd0);
    end
    s_rdy_i = 1'b1;
    wait_idle();
    chk("post_last_addr", 32'(last_sacc.addr), 32'h14);
    chk("post_last_data", 32'(last_sacc.data), 32'hA4);

    // Reset while writes are waiting: nothing may reach the slave afterwards.
    s_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) send(WR, 15'(16'h40 + i), 16'(16'hB0 + i), 2'b11);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_s_op", 32'(s_op_o), 32'(NOP));
    chk("rst_mid_wq_cnt", 32'(wq_cnt_o), 32'd0);
    chk("rst_mid_m_rdy", 32'(m_rdy_o), 32'd1);
    cyc();
    rst_i = 1'b0;
    s_rdy_i = 1'b1;
    base = n_sacc;
    repeat (10) cyc();
    chk("no_write_after_rst", 32'(n_sacc - base), 32'd0);

    // Read after write to the same address.
    s_data_i = 16'h5555;
    send(WR, 15'h20, 16'h5555, 2'b11);
    send(RD, 15'h20, 16'h0000, 2'b11);
    wait_idle();
    chk("raw_m_data", 32'(m_data_o), 32'h5555);
    chk("raw_last_op", 32'(last_sacc.op), 32'(RD));
    chk("raw_last_addr", 32'(last_sacc.addr), 32'h20);

    // Streaming writes with two entries backlogged: occupancy stays at two.
    s_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) send(WR, 15'(16'h50 + i), 16'(16'hC0 + i), 2'b11);
    chk("stream_pre_cnt", 32'(wq_cnt_o), 32'd2);
    s_rdy_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(WR, 15'(16'h60 + i), 16'(16'hD0 + i), 2'b10);
      chk("stream_wq_cnt", 32'(wq_cnt_o), 32'd2);
      chk("stream_m_rdy", 32'(m_rdy_o), 32'd1);
    end
    wait_idle();
    chk("stream_last_addr", 32'(last_sacc.addr), 32'h67);

    // Read-write with a partial byte select.
    s_data_i = 16'h1234;
    send(RW, 15'h30, 16'h00FF, 2'b01);
    wait_idle();
    chk("rw_m_data", 32'(m_data_o), 32'h1234);
    chk("rw_last_op", 32'(last_sacc.op), 32'(RW));
    chk("rw_last_sel", 32'(last_sacc.sel), 32'h1);
    chk("rw_last_data", 32'(last_sacc.data), 32'h00FF);

    // Slave stalls after taking a read: master side must hold.
    s_data_i = 16'hCAFE;
    send(RD, 15'h31, 16'h0000, 2'b11);
    n = 0;
    @(negedge clk);
    while (s_op_o != RD && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("issue_timeout", 32'(s_op_o), 32'(RD));
    cyc();
    s_rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_m_rdy", 32'(m_rdy_o), 32'd0);
      chk("stall_m_data", 32'(m_data_o), 32'h1234);
    end
    s_rdy_i = 1'b1;
    wait_idle();
    chk("stall_done_m_data", 32'(m_data_o), 32'hCAFE);

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
